// File: rtl/mmio_ctrl_ws.sv
// rtl/mmio_ctrl_ws.sv - FPro MMIO slot controller with per-slot wait states, bus timeout and sticky error
module mmio_ctrl_ws #(
  parameter int          N_SLOT   = 64,
  parameter int          REG_AW   = 5,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
  localparam int         SLOT_AW  = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mmio_cs,
  input  logic                 mmio_wr,
  input  logic                 mmio_rd,
  input  logic [20:0]          mmio_addr,
  input  logic [31:0]          mmio_wr_data,
  output logic [31:0]          mmio_rd_data,
  output logic                 mmio_ready,
  output logic [N_SLOT-1:0]    slot_cs_array,
  output logic [N_SLOT-1:0]    slot_mem_rd_array,
  output logic [N_SLOT-1:0]    slot_mem_wr_array,
  output logic [REG_AW-1:0]    slot_reg_addr,
  output logic [31:0]          slot_wr_data,
  input  logic [32*N_SLOT-1:0] slot_rd_data_array,
  input  logic [N_SLOT-1:0]    slot_ready_array,
  output logic                 err_flag,
  output logic [SLOT_AW-1:0]   err_slot,
  input  logic                 err_clr
);

  localparam int ADDR_SW = 21 - REG_AW;
  localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]         state;
  logic               op_wr;
  logic [SLOT_AW-1:0] slot_q;
  logic [CW-1:0]      cnt;

  // The whole upper address field is decoded so slots beyond N_SLOT are caught.
  logic [ADDR_SW-1:0] addr_slot;
  logic               slot_oob;
  logic               accept;
  logic               sel_ready;
  logic [31:0]        sel_data;
  logic               timeout_hit;
  logic               err_set;
  logic [N_SLOT-1:0]  slot_onehot;

  assign addr_slot   = mmio_addr[20:REG_AW];
  assign slot_oob    = 32'(addr_slot) >= N_SLOT;
  assign accept      = (state == IDLE) && mmio_cs && (mmio_rd || mmio_wr);
  assign sel_ready   = slot_ready_array[slot_q];
  assign sel_data    = slot_rd_data_array[32*slot_q +: 32];
  assign timeout_hit = (TIMEOUT != 0) && !sel_ready && (cnt == CNT_LAST);
  assign err_set     = (accept && slot_oob) || ((state == ACCESS) && timeout_hit);
  assign slot_onehot = N_SLOT'(1) << slot_q;
  assign mmio_ready  = (state == DONE);

  always_comb begin
    slot_cs_array     = '0;
    slot_mem_rd_array = '0;
    slot_mem_wr_array = '0;
    if (state == ACCESS) begin
      slot_cs_array = slot_onehot;
      if (op_wr) slot_mem_wr_array = slot_onehot;
      else       slot_mem_rd_array = slot_onehot;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      op_wr         <= 1'b0;
      slot_q        <= '0;
      cnt           <= '0;
      mmio_rd_data  <= '0;
      slot_reg_addr <= '0;
      slot_wr_data  <= '0;
      err_flag      <= 1'b0;
      err_slot      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_wr         <= mmio_wr;
            slot_q        <= addr_slot[SLOT_AW-1:0];
            slot_reg_addr <= mmio_addr[REG_AW-1:0];
            slot_wr_data  <= mmio_wr_data;
            cnt           <= '0;
            if (slot_oob) begin
              mmio_rd_data <= ERR_DATA;
              err_slot     <= addr_slot[SLOT_AW-1:0];
              state        <= DONE;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // A ready on the last allowed cycle wins over the watchdog.
          if (sel_ready) begin
            if (!op_wr) mmio_rd_data <= sel_data;
            state <= DONE;
          end else if (timeout_hit) begin
            mmio_rd_data <= ERR_DATA;
            err_slot     <= slot_q;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (err_set)      err_flag <= 1'b1;
      else if (err_clr) err_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_ctrl_ws.sv
// tb/tb_mmio_ctrl_ws.sv - self-checking bench for mmio_ctrl_ws with a cycle-timeline model
module tb_mmio_ctrl_ws;
  localparam int NS = 16, RA = 5, TO = 8, SAW = 4, MAXC = 512;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mmio_cs = 1'b0, mmio_wr = 1'b0, mmio_rd = 1'b0;
  logic [20:0] mmio_addr = '0;
  logic [31:0] mmio_wr_data = '0;
  logic [31:0] mmio_rd_data;
  logic mmio_ready;
  logic [NS-1:0] slot_cs_array, slot_mem_rd_array, slot_mem_wr_array;
  logic [RA-1:0] slot_reg_addr;
  logic [31:0] slot_wr_data;
  logic [32*NS-1:0] slot_rd_data_array = '0;
  logic [NS-1:0] slot_ready_array;
  logic err_flag;
  logic [SAW-1:0] err_slot;
  logic err_clr;

  int cyc = 0, checks = 0, errors = 0, rd_hi = 0, wr_hi = 0;

  // Expected timeline, indexed by cycle number; filled per transaction from the protocol rules.
  bit [NS-1:0]  rdy_sched[MAXC], e_cs[MAXC];
  bit           e_wop[MAXC], e_rdy[MAXC], e_rdv[MAXC], e_eset[MAXC], e_latv[MAXC], clr_sched[MAXC];
  bit [31:0]    e_rdat[MAXC], e_wd[MAXC];
  bit [SAW-1:0] e_eslot[MAXC];
  bit [RA-1:0]  e_reg[MAXC];
  logic [31:0]    m_rd = '0, m_wd = '0;
  logic           m_ef = 1'b0;
  logic [SAW-1:0] m_es = '0;
  logic [RA-1:0]  m_reg = '0;

  assign slot_ready_array = rdy_sched[cyc];
  assign err_clr          = clr_sched[cyc];

  mmio_ctrl_ws #(.N_SLOT(NS), .REG_AW(RA), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset), .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
    .mmio_ready(mmio_ready), .slot_cs_array(slot_cs_array), .slot_mem_rd_array(slot_mem_rd_array),
    .slot_mem_wr_array(slot_mem_wr_array), .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data),
    .slot_rd_data_array(slot_rd_data_array), .slot_ready_array(slot_ready_array),
    .err_flag(err_flag), .err_slot(err_slot), .err_clr(err_clr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (reset) begin
        m_rd = '0; m_wd = '0; m_ef = 1'b0; m_es = '0; m_reg = '0;
      end else begin
        if (e_latv[cyc]) begin m_reg = e_reg[cyc]; m_wd = e_wd[cyc]; end
        if (e_rdv[cyc]) m_rd = e_rdat[cyc];
        if (e_eset[cyc]) begin m_ef = 1'b1; m_es = e_eslot[cyc]; end
        else if (clr_sched[cyc-1]) m_ef = 1'b0;
      end
      chk("cs", slot_cs_array, e_cs[cyc]);
      chk("mem_rd", slot_mem_rd_array, e_wop[cyc] ? NS'(0) : e_cs[cyc]);
      chk("mem_wr", slot_mem_wr_array, e_wop[cyc] ? e_cs[cyc] : NS'(0));
      chk("ready", mmio_ready, e_rdy[cyc]);
      chk("rd_data", mmio_rd_data, m_rd);
      chk("err_flag", err_flag, m_ef);
      chk("err_slot", err_slot, m_es);
      chk("reg_addr", slot_reg_addr, m_reg);
      chk("wr_data", slot_wr_data, m_wd);
    end
    if (|slot_mem_rd_array) rd_hi++;
    if (|slot_mem_wr_array) wr_hi++;
  end

  // Issue a one-cycle request at the current cycle; returns the cycle mmio_ready must pulse.
  task automatic start_txn(input bit wr, input bit rd, input int slot, input int reg_a,
                           input logic [31:0] wdata, input int wait_n, input logic [31:0] sdata,
                           output int t0, output int done);
    int n;
    bit ok;
    t0 = cyc; rd_hi = 0; wr_hi = 0;
    mmio_cs = 1'b1; mmio_wr = wr; mmio_rd = rd;
    mmio_addr = 21'((slot << RA) + reg_a); mmio_wr_data = wdata;
    e_latv[t0+1] = 1'b1; e_reg[t0+1] = RA'(reg_a); e_wd[t0+1] = wdata;
    if (slot >= NS) begin
      done = t0 + 1;
      e_rdv[done] = 1'b1; e_rdat[done] = ERR; e_eset[done] = 1'b1; e_eslot[done] = SAW'(slot);
    end else begin
      ok = (wait_n < TO);
      n = ok ? wait_n + 1 : TO;
      done = t0 + n + 1;
      slot_rd_data_array[32*slot +: 32] = sdata;
      for (int k = 1; k <= n; k++) begin e_cs[t0+k] = NS'(1) << slot; e_wop[t0+k] = wr; end
      if (ok) begin
        rdy_sched[t0+n] = NS'(1) << slot;
        if (!wr) begin e_rdv[done] = 1'b1; e_rdat[done] = sdata; end
      end else begin
        e_rdv[done] = 1'b1; e_rdat[done] = ERR; e_eset[done] = 1'b1; e_eslot[done] = SAW'(slot);
      end
    end
    e_rdy[done] = 1'b1;
    @(posedge clk); #1;
    mmio_cs = 1'b0; mmio_wr = 1'b0; mmio_rd = 1'b0;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, done;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_data", mmio_rd_data, 32'h0);
    chk("rst_ready", mmio_ready, 1'b0);
    chk("rst_err", err_flag, 1'b0);
    reset = 1'b0;
    next_cycle();

    // Read slot 3 reg 2, ready at once
    start_txn(1'b0, 1'b1, 3, 2, 32'h0, 0, 32'h1234_5678, t0, done);
    chk("t1_reg_addr", slot_reg_addr, 5'd2);
    chk("t1_cs_held", slot_cs_array, 16'h0008);
    go_to(done);
    chk("t1_latency", done - t0, 2);
    chk("t1_ready", mmio_ready, 1'b1);
    chk("t1_rd_data", mmio_rd_data, 32'h1234_5678);
    chk("t1_strobe_cycles", rd_hi, 1);
    next_cycle();

    // Write slot 7 with 4 wait cycles
    start_txn(1'b1, 1'b0, 7, 1, 32'hA5A5_0001, 4, 32'h0, t0, done);
    go_to(done);
    chk("t2_latency", done - t0, 6);
    chk("t2_wr_cycles", wr_hi, 5);
    chk("t2_wr_data", slot_wr_data, 32'hA5A5_0001);
    chk("t2_rd_kept", mmio_rd_data, 32'h1234_5678);
    chk("t2_err", err_flag, 1'b0);
    next_cycle();

    // Ready on the last allowed cycle is a success
    start_txn(1'b0, 1'b1, 5, 0, 32'h0, TO - 1, 32'h0BAD_F00D, t0, done);
    go_to(done);
    chk("edge_rd_cycles", rd_hi, 8);
    chk("edge_rd_data", mmio_rd_data, 32'h0BAD_F00D);
    chk("edge_err", err_flag, 1'b0);
    next_cycle();

    // rd and wr together is a write
    start_txn(1'b1, 1'b1, 1, 3, 32'h0000_00C3, 0, 32'h0, t0, done);
    go_to(done);
    chk("both_wr_cycles", wr_hi, 1);
    chk("both_rd_cycles", rd_hi, 0);
    next_cycle();

    // Timeout on slot 9
    start_txn(1'b0, 1'b1, 9, 4, 32'h0, 1000, 32'h0, t0, done);
    go_to(done);
    chk("to_latency", done - t0, 9);
    chk("to_strobe_cycles", rd_hi, 8);
    chk("to_rd_data", mmio_rd_data, 32'hDEAD_BEEF);
    chk("to_err", err_flag, 1'b1);
    chk("to_err_slot", err_slot, 4'd9);
    next_cycle();

    clr_sched[cyc] = 1'b1;
    next_cycle();
    chk("clr_alone", err_flag, 1'b0);

    // Out-of-range slot 20
    start_txn(1'b0, 1'b1, 20, 0, 32'h0, 0, 32'h0, t0, done);
    go_to(done);
    chk("oob_latency", done - t0, 1);
    chk("oob_strobes", rd_hi, 0);
    chk("oob_rd_data", mmio_rd_data, 32'hDEAD_BEEF);
    chk("oob_err", err_flag, 1'b1);
    chk("oob_err_slot", err_slot, 4'd4);
    next_cycle();
    clr_sched[cyc] = 1'b1;
    next_cycle();

    // err_clr on the timeout cycle: set wins
    clr_sched[cyc + TO] = 1'b1;
    start_txn(1'b0, 1'b1, 2, 0, 32'h0, 1000, 32'h0, t0, done);
    go_to(done);
    chk("set_wins_err", err_flag, 1'b1);
    chk("set_wins_slot", err_slot, 4'd2);
    next_cycle();

    // Reset in the third ACCESS cycle
    start_txn(1'b0, 1'b1, 4, 0, 32'h0, 1000, 32'h4444_4444, t0, done);
    next_cycle();
    next_cycle();
    chk("pre_rst_cs", slot_cs_array, 16'h0010);
    chk("pre_rst_err", err_flag, 1'b1);
    reset = 1'b1;
    for (int c = cyc; c < MAXC; c++) begin
      rdy_sched[c] = '0; e_cs[c] = '0; e_wop[c] = 0; e_rdy[c] = 0; e_rdv[c] = 0;
      e_eset[c] = 0; e_latv[c] = 0; clr_sched[c] = 0;
    end
    #1;
    chk("rst_async_cs", slot_cs_array, 16'h0);
    chk("rst_async_rd", slot_mem_rd_array, 16'h0);
    chk("rst_async_err", err_flag, 1'b0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    start_txn(1'b0, 1'b1, 0, 0, 32'h0, 0, 32'h600D_0000, t0, done);
    go_to(done);
    chk("post_rst_ready", mmio_ready, 1'b1);
    chk("post_rst_rd", mmio_rd_data, 32'h600D_0000);
    next_cycle();
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/mmio_ctrl_ws.md
Name: mmio_ctrl_ws

Overview:
Parametrised MMIO slot controller for the FPro bus. It adds per-slot wait-state handshaking, a bus-timeout watchdog and sticky error reporting to the fixed-latency slot decode. It sits between the FPro bus master and N_SLOT I/O cores in the MMIO subsystem. Cores that need no wait states tie their ready bit high.

Parameters:
N_SLOT, 64, number of slots; slot field width SLOT_AW = clog2(N_SLOT), minimum 1.
REG_AW, 5, register-address bits per slot.
TIMEOUT, 255, ACCESS cycles allowed before abort; 0 disables the watchdog.
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout or on an out-of-range slot.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mmio_cs  in  1  bus select
mmio_wr  in  1  write request
mmio_rd  in  1  read request
mmio_addr  in  21  word address; reg = [REG_AW-1:0], slot = [REG_AW +: SLOT_AW]
mmio_wr_data  in  32  write data
mmio_rd_data  out  32  registered read data
mmio_ready  out  1  one-cycle completion pulse
slot_cs_array  out  N_SLOT  one-hot slot select
slot_mem_rd_array  out  N_SLOT  read strobe per slot
slot_mem_wr_array  out  N_SLOT  write strobe per slot
slot_reg_addr  out  REG_AW  latched register address, shared by all slots
slot_wr_data  out  32  latched write data, shared by all slots
slot_rd_data_array  in  32*N_SLOT  flattened read data; slot i is at [32*i +: 32]
slot_ready_array  in  N_SLOT  per-slot done
err_flag  out  1  sticky error
err_slot  out  SLOT_AW  slot index of the most recent error
err_clr  in  1  clears err_flag

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high; asserting it at any time, including mid-transaction, forces state IDLE and clears every register.
- Reset values: all array outputs 0, mmio_rd_data 0, mmio_ready 0, err_flag 0, err_slot 0, slot_reg_addr 0, slot_wr_data 0, timeout counter 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Accept when mmio_cs & (mmio_rd | mmio_wr).
  - On accept, latch op, slot, reg address and write data. If both rd and wr are set, the request is a write.
  - If slot >= N_SLOT: go to DONE with rd data = ERR_DATA, set err_flag, err_slot = slot[SLOT_AW-1:0]. No slot is strobed.
  - Otherwise go to ACCESS.
- ACCESS:
  - slot_cs_array[slot] = 1; the matching mem_rd or mem_wr bit = 1. These are held every ACCESS cycle. All other bits are 0.
  - When slot_ready_array[slot] = 1 in the same cycle: capture slot_rd_data_array[slot] into mmio_rd_data (reads only; writes leave it unchanged). Go to DONE.
  - Otherwise increment the counter. If TIMEOUT != 0 and counter == TIMEOUT-1 with ready still low: mmio_rd_data = ERR_DATA, set err_flag, err_slot = slot, go to DONE.
  - Strobes drop in the cycle after ACCESS exits.
- DONE: mmio_ready = 1 for exactly one cycle, counter cleared, go to IDLE. A request present in DONE is ignored; a new request is accepted in IDLE the next cycle.
- Latency: accept at cycle 0, ACCESS at cycle 1; with ready high, mmio_ready pulses at cycle 2. Each wait cycle adds 1.
- Requests arriving during ACCESS or DONE are ignored. The master holds off until mmio_ready.
- Read data is undefined-but-stable between completions: mmio_rd_data holds its last value.
- Error flag:
  - err_clr clears err_flag.
  - If an error-set and err_clr occur in the same cycle, set wins.
  - err_slot updates only on a new error.
- Timeout window: TIMEOUT = 1 allows exactly one ACCESS cycle. A ready that arrives on the final allowed cycle counts as success, not timeout.

Test Plan:
- Read, slot 3 reg 2, ready tied high, slot data 0x1234_5678 → slot_cs[3] and mem_rd[3] high for 1 cycle, slot_reg_addr = 2; mmio_ready at cycle 2; mmio_rd_data = 0x1234_5678.
- Write 0xA5A5_0001 to slot 7, ready asserted after 4 wait cycles → mem_wr[7] held 5 cycles with slot_wr_data = 0xA5A5_0001; mmio_ready at cycle 6; no error.
- TIMEOUT = 8, read slot 9 with ready never asserted → strobe for 8 cycles; mmio_rd_data = 0xDEAD_BEEF; err_flag = 1; err_slot = 9.
- N_SLOT = 16, read at slot 20 → no strobe; mmio_ready at cycle 1 after DONE; rd = 0xDEAD_BEEF; err_flag = 1.
- Assert err_clr in the same cycle as a new timeout → err_flag stays 1. err_clr alone → 0.
- Assert reset in the 3rd ACCESS cycle → all strobes 0 immediately, state IDLE, err_flag 0. A subsequent read of slot 0 completes normally.
